// File: rtl/buttons_conditioner.sv
// rtl/buttons_conditioner.sv - synchronise, debounce and arbitrate N push-buttons into one-hot press pulses
module buttons_conditioner #(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit REPEAT_EN       = 1'b0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] btn_level,
    output logic             conflict
);
    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam int OW   = (N_BTN > 1) ? $clog2(N_BTN) : 1;

    localparam logic [CW-1:0]    DB_LAST     = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0]    DELAY_LOAD  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0]    PERIOD_LOAD = RW'(REPEAT_PERIOD - 1);
    localparam logic [N_BTN-1:0] ONE         = N_BTN'(1);

    typedef enum logic [1:0] {IDLE, HELD, LOCKOUT} state_t;

    logic [N_BTN-1:0] sync1, sync2;
    state_t           state, state_next;
    logic [OW-1:0]    owner, owner_next, level_idx;
    logic [RW-1:0]    rep_cnt, rep_cnt_next;
    logic [N_BTN-1:0] pulse_next, owner_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // The counter only runs while the synchronised input disagrees with the accepted level.
    for (genvar i = 0; i < N_BTN; i++) begin : g_debounce
        logic [CW-1:0] cnt;
        logic          level;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt   <= '0;
                level <= 1'b0;
            end else if (sync2[i] == level) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                level <= sync2[i];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end

        assign btn_level[i] = level;
    end

    // Index is only consumed when btn_level is one-hot, so priority order is irrelevant.
    always_comb begin
        level_idx = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (btn_level[i]) level_idx = OW'(i);
        end
    end

    assign owner_mask = ONE << owner;

    always_comb begin
        state_next   = state;
        owner_next   = owner;
        rep_cnt_next = rep_cnt;
        pulse_next   = '0;
        case (state)
            IDLE: begin
                if ($onehot(btn_level)) begin
                    pulse_next   = btn_level;
                    owner_next   = level_idx;
                    rep_cnt_next = DELAY_LOAD;
                    state_next   = HELD;
                end else if (btn_level != '0) begin
                    state_next = LOCKOUT;
                end
            end
            HELD: begin
                if (btn_level == owner_mask) begin
                    if (REPEAT_EN) begin
                        if (rep_cnt == '0) begin
                            pulse_next   = owner_mask;
                            rep_cnt_next = PERIOD_LOAD;
                        end else begin
                            rep_cnt_next = rep_cnt - RW'(1);
                        end
                    end
                end else if (btn_level == '0) begin
                    state_next = IDLE;
                end else begin
                    state_next = LOCKOUT;
                end
            end
            LOCKOUT: begin
                if (btn_level == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= '0;
            rep_cnt     <= '0;
            press_pulse <= '0;
        end else begin
            state       <= state_next;
            owner       <= owner_next;
            rep_cnt     <= rep_cnt_next;
            press_pulse <= pulse_next;
        end
    end

    assign conflict = (state == LOCKOUT);
endmodule

// File: doc/buttons_conditioner.md
Name: buttons_conditioner

Overview:
- Parametrised successor to the three-button input driver for the game controls.
- Synchronises and debounces N raw push-buttons, then arbitrates so that only one button is accepted at a time.
- Emits a single-cycle press pulse per accepted press, with optional auto-repeat while the button is held.
- Sits between the board pins and the player movement/rotation logic.

Parameters:
- N_BTN, 3, number of button channels (≥1); bit 0 = rotate -90, bit 1 = forward, bit 2 = rotate +90 in the default build.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required before a level change is accepted (≥1).
- REPEAT_EN, 0, 1 = auto-repeat pulses while the accepted button is held.
- REPEAT_DELAY, 25000000, cycles from the first pulse to the first repeat pulse (≥1).
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses (≥1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- btn_raw  input  N_BTN  raw button pins, active-high, asynchronous to clk.
- press_pulse  output  N_BTN  one-hot single-cycle press/repeat pulse, zero otherwise.
- btn_level  output  N_BTN  debounced level of each button.
- conflict  output  1  high while the block is in LOCKOUT.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All synchroniser flops, debounced levels, counters and press_pulse clear to 0; conflict clears to 0; FSM goes to IDLE.
  - Deasserting rst_n mid-press restarts debounce from a released state.
- Synchroniser: 2-flop per bit; sync2 reflects btn_raw 2 edges after a change.
- Debounce, per channel independently:
  - Counter width = clog2(DEBOUNCE_CYCLES+1).
  - sync2 == btn_level → counter cleared.
  - Otherwise the counter increments; on the edge where it equals DEBOUNCE_CYCLES-1, btn_level takes sync2 and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes btn_level.
  - Release is debounced identically.
- Arbitration FSM, states IDLE, HELD, LOCKOUT; owner register of clog2(N_BTN) bits:
  - IDLE, btn_level == 0: stay.
  - IDLE, btn_level exactly one-hot: assert that bit of press_pulse next cycle, latch owner, load repeat counter with REPEAT_DELAY-1, go to HELD.
  - IDLE, ≥2 bits set: go to LOCKOUT, no pulse.
  - HELD, btn_level == only the owner bit: if REPEAT_EN, decrement the repeat counter. At 0, pulse the owner bit and reload REPEAT_PERIOD-1. If REPEAT_EN=0, no further pulses.
  - HELD, btn_level == 0: go to IDLE.
  - HELD, any non-owner bit set (with or without the owner): go to LOCKOUT, no pulse.
  - LOCKOUT: conflict=1; stay until btn_level == 0, then IDLE (conflict=0 the same edge).
- Simultaneous debounced rises on the same edge count as multiple → LOCKOUT.
- A second press requires full release (btn_level == 0) first; holding never produces extra pulses unless REPEAT_EN.
- Latency: raw edge held stable → btn_level changes at edge 2+DEBOUNCE_CYCLES → press_pulse high for exactly 1 cycle at edge 3+DEBOUNCE_CYCLES.
- press_pulse is registered; at most one bit is high in any cycle.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=6, REPEAT_PERIOD=3 unless stated):
- Press bit 1 stable for 20 cycles → btn_level[1] rises at edge 6, press_pulse=3'b010 for one cycle at edge 7, no further pulses (REPEAT_EN=0), conflict=0.
- Bit 0 raw bounces 1,0,1,0 over 3-cycle pulses, then held → no pulse during bouncing; exactly one pulse of 3'b001, 7 edges after the final stable rise.
- Hold bit 2 from IDLE, then press bit 0 while bit 2 is held → one pulse 3'b100; conflict=1 after bit 0 debounces; no pulse for bit 0; release both → conflict=0, IDLE; press bit 0 → pulse 3'b001.
- Bits 0 and 2 raised on the same cycle → no pulse, conflict=1 until both are released and debounced.
- REPEAT_EN=1, hold bit 1 for 30 cycles after its first pulse → pulses at +6, +9, +12, ... cycles relative to the first pulse; release → pulses stop, IDLE.
- Assert rst_n=0 mid-debounce and mid-HELD → all outputs 0 immediately (asynchronous); after release of reset, a held button produces a fresh pulse after DEBOUNCE_CYCLES+3 edges.
